// File: rtl/gen_debounce_pkg.sv
// Shared definitions for the level debouncer: the state encoding and the
// parameter-legality check used at elaboration.
package gen_debounce_pkg;

    typedef enum logic [1:0] {
        ST_LO  = 2'd0,
        CHK_HI = 2'd1,
        ST_HI  = 2'd2,
        CHK_LO = 2'd3
    } db_state_t;

    // The counter must be able to hold STABLE_CYCLES-1 without wrapping.
    function automatic bit params_ok(input int stable_cycles, input int cnt_w);
        if (stable_cycles < 2) return 1'b0;
        if (cnt_w < 1 || cnt_w > 30) return 1'b0;
        return (1 << cnt_w) > stable_cycles;
    endfunction

endpackage

// File: rtl/gen_debounce.sv
// Level debouncer with one-cycle rise/fall strobes for an already-synchronized
// input. A new level is accepted after STABLE_CYCLES consecutive samples.
module gen_debounce
    import gen_debounce_pkg::*;
#(
    parameter int   STABLE_CYCLES = 16,
    parameter int   CNT_W         = 5,
    parameter logic RST_VAL       = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic data_syn,
    output logic data_stable,
    output logic rise_pulse,
    output logic fall_pulse
);

    if (!params_ok(STABLE_CYCLES, CNT_W)) begin : g_bad_params
        $error("gen_debounce: need STABLE_CYCLES >= 2 and 2**CNT_W > STABLE_CYCLES");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam db_state_t        ST_RST   = RST_VAL ? ST_HI : ST_LO;

    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        stable_d = stable_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        case (state_q)
            ST_LO: begin
                if (data_syn) begin
                    state_d = CHK_HI;
                    cnt_d   = CNT_W'(1);
                end
            end
            CHK_HI: begin
                // A single low sample discards the whole candidate run.
                if (!data_syn) begin
                    state_d = ST_LO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = ST_HI;
                    stable_d = 1'b1;
                    rise_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HI: begin
                if (!data_syn) begin
                    state_d = CHK_LO;
                    cnt_d   = CNT_W'(1);
                end
            end
            CHK_LO: begin
                if (data_syn) begin
                    state_d = ST_HI;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = ST_LO;
                    stable_d = 1'b0;
                    fall_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_RST;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_RST;
            cnt_q    <= '0;
            stable_q <= RST_VAL;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign data_stable = stable_q;
    assign rise_pulse  = rise_q;
    assign fall_pulse  = fall_q;

endmodule

// File: tb/tb_gen_debounce.sv
// Randomized and directed bench for gen_debounce against a run-length model
// of the debounce rule (STABLE_CYCLES = 4, RST_VAL = 0).
module tb_gen_debounce;

    localparam int S = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic data_syn = 1'b0;
    logic data_stable, rise_pulse, fall_pulse;

    int vectors = 0;
    int miscompares = 0;

    // Model: accepted level plus length of the current run of differing samples.
    logic m_lvl;
    int   m_run;
    logic m_rise, m_fall;

    logic [2:0] exp_q[$];

    gen_debounce #(
        .STABLE_CYCLES(S),
        .CNT_W(3),
        .RST_VAL(1'b0)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .data_syn(data_syn),
        .data_stable(data_stable),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [2:0] got, input logic [2:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got {stable,rise,fall}=%b expected %b at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_lvl  = 1'b0;
        m_run  = 0;
        m_rise = 1'b0;
        m_fall = 1'b0;
    endtask

    task automatic model_edge(input logic d);
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (d != m_lvl) begin
            m_run++;
            if (m_run == S) begin
                m_lvl  = d;
                m_rise = d;
                m_fall = ~d;
                m_run  = 0;
            end
        end else begin
            m_run = 0;
        end
    endtask

    // Drive one sample, let the edge take it, then compare one cycle of outputs.
    task automatic step(input logic d, input string tag);
        logic [2:0] exp;
        data_syn = d;
        @(posedge CLK);
        model_edge(d);
        exp_q.push_back({m_lvl, m_rise, m_fall});
        #1;
        exp = exp_q.pop_front();
        check_eq(tag, {data_stable, rise_pulse, fall_pulse}, exp);
    endtask

    task automatic hold(input logic d, input int n, input string tag);
        for (int i = 0; i < n; i++) step(d, tag);
    endtask

    // Assert reset mid-cycle, check outputs clear before any edge, release at negedge.
    task automatic async_reset(input string tag);
        #2;
        RST = 1'b1;
        #1;
        model_reset();
        check_eq(tag, {data_stable, rise_pulse, fall_pulse}, 3'b000);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        model_reset();
        data_syn = 1'b1;
        #1;
        check_eq("reset_initial", {data_stable, rise_pulse, fall_pulse}, 3'b000);
        @(negedge CLK);
        @(negedge CLK);
        check_eq("reset_held", {data_stable, rise_pulse, fall_pulse}, 3'b000);
        data_syn = 1'b0;
        RST = 1'b0;

        hold(1'b0, 3, "idle_low");
        hold(1'b1, 6, "clean_rise");
        async_reset("reset_from_high");
        hold(1'b0, 4, "post_reset_low");

        hold(1'b1, 3, "glitch_high");
        hold(1'b0, 3, "glitch_end");
        hold(1'b1, S, "exact_accept");
        hold(1'b1, 4, "high_hold");

        hold(1'b0, S - 1, "fall_short");
        step(1'b1, "fall_abort");
        hold(1'b0, S + 2, "clean_fall");

        for (int i = 0; i < 50; i++) step(logic'(i[0] == 1'b0), "chatter_lo");
        hold(1'b1, 6, "rise_before_chatter");
        for (int i = 0; i < 50; i++) step(logic'(i[0] == 1'b1), "chatter_hi");
        hold(1'b0, 6, "fall_after_chatter");

        hold(1'b1, 2, "midqual_high");
        async_reset("midqual_reset");
        hold(1'b1, 6, "midqual_resume");
        hold(1'b0, 5, "midqual_fall");

        for (int r = 0; r < 120; r++) begin
            logic lvl;
            int   len;
            lvl = logic'($urandom_range(0, 1));
            len = $urandom_range(1, S + 2);
            hold(lvl, len, "random_run");
            if ($urandom_range(0, 29) == 0) async_reset("random_reset");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gen_debounce.md
# gen_debounce

Level debouncer and edge detector for single-bit asynchronous inputs such as buttons, straps and external interrupt lines. It sits directly downstream of the two-flop synchronizer and takes the synchronizer's output as its input. It outputs a glitch-filtered level, plus one-cycle rise and fall pulses, for interrupt and GPIO logic. The input must already be synchronous to `CLK`; the block adds no metastability protection.

## Interface

Parameters:
- `STABLE_CYCLES`, default 16: consecutive identical samples required to accept a new level. Legal range is at least 2; elaboration fails below 2.
- `CNT_W`, default 5: counter width. Must satisfy 2^CNT_W > STABLE_CYCLES; elaboration check.
- `RST_VAL`, default 0: level assumed and driven on `data_stable` during and after reset.

Ports:
- `CLK`  in  1  sole clock; all state updates on the rising edge.
- `RST`  in  1  asynchronous, active-high reset. Assertion clears state immediately; release is synchronous to `CLK` (provided by the reset tree).
- `data_syn`  in  1  synchronized raw level from the upstream synchronizer.
- `data_stable`  out  1  debounced level, registered.
- `rise_pulse`  out  1  one-cycle strobe on an accepted 0→1 change, registered.
- `fall_pulse`  out  1  one-cycle strobe on an accepted 1→0 change, registered.

## Operation

- FSM has four states:
  - `ST_LO`: accepted level 0, idle.
  - `CHK_HI`: candidate level 1 being qualified.
  - `ST_HI`: accepted level 1, idle.
  - `CHK_LO`: candidate level 0 being qualified.
- Reset: state = `ST_HI` if `RST_VAL` = 1, else `ST_LO`. `cnt` = 0, `data_stable` = `RST_VAL`, `rise_pulse` = 0, `fall_pulse` = 0.
- `ST_LO`:
  - `data_syn` = 1 → `CHK_HI`, `cnt` <= 1.
  - Otherwise hold, `cnt` <= 0.
- `CHK_HI`:
  - `data_syn` = 0 → `ST_LO`, `cnt` <= 0. The glitch is discarded and no pulse is emitted.
  - `data_syn` = 1 and `cnt` == `STABLE_CYCLES`-1 → `ST_HI`, `data_stable` <= 1, `rise_pulse` <= 1, `cnt` <= 0.
  - `data_syn` = 1 otherwise → `cnt` <= `cnt`+1.
- `ST_HI` and `CHK_LO` mirror the above with polarity inverted. `CHK_LO` completing sets `data_stable` <= 0 and `fall_pulse` <= 1.
- Pulses are cleared on every edge where they are not being set. A pulse is therefore never wider than one cycle.
- `cnt` never exceeds `STABLE_CYCLES`-1, so no wrap-around is possible.

## Timing

- Latency: let edge k be the first edge that samples the new level. If edges k through k+`STABLE_CYCLES`-1 all sample that level, then `data_stable` and the matching pulse change at edge k+`STABLE_CYCLES`-1.
- A level held for exactly `STABLE_CYCLES` samples is accepted. A level held for `STABLE_CYCLES`-1 samples is rejected.
- The pulse and the `data_stable` change appear on the same edge.
- `rise_pulse` and `fall_pulse` are never high together.
- Minimum spacing between two pulses is `STABLE_CYCLES` cycles.
- Alternating input (period 2 samples): the block never leaves the CHK state pair with its current accepted level. Output holds and no pulses are emitted.
- `RST` asserted mid-qualification: qualification is aborted, and all outputs return to their reset values asynchronously. No pulse is emitted on reset entry or exit.
- After reset release, if `data_syn` differs from `RST_VAL`, the new level is qualified normally and its pulse is emitted. This is the intended behaviour for straps.

## Structure

- A shared header holds:
  - the state encoding localparams `ST_LO`, `CHK_HI`, `ST_HI`, `CHK_LO` (2-bit, binary);
  - the elaboration-check macro for the parameter constraints.
- No sub-module is needed. FSM, counter and output registers are inline.
- The existing `gen_dffr` primitive is active-low, so registers are written directly with the active-high asynchronous reset.
- The integrating parent instantiates `gen_syn` followed by `gen_debounce`.

## Test plan

All scenarios use `STABLE_CYCLES` = 4 and `RST_VAL` = 0.

- Reset: assert `RST` with `data_syn` = 1 → `data_stable` = 0 and both pulses 0 immediately, without a clock edge.
- Clean rise: `data_syn` goes 0→1 and is first sampled at edge 10, held → `data_stable` = 1 and `rise_pulse` = 1 after edge 13; `rise_pulse` = 0 after edge 14.
- Glitch reject: `data_syn` high for 3 samples (edges 10–12), low at 13 → `data_stable` stays 0, no pulse. A following 4-sample high is accepted normally.
- Clean fall from `ST_HI`: `data_syn` low sampled at edges 20–23 → `data_stable` = 0 and `fall_pulse` = 1 after edge 23; `rise_pulse` stays 0 throughout.
- Chatter: `data_syn` toggles every cycle for 50 cycles → no pulses, `data_stable` unchanged.
- Mid-qualification reset: `data_syn` high at edges 10–11, `RST` pulsed between edges 11 and 12, then high held → acceptance counts from the first post-reset edge, i.e. 4 samples after release. Exactly one `rise_pulse`.
